// File: rtl/mux8_bits_rr_collector_if.sv
// Bundle of the eight source buses, request/ack lines and the output slot handshake.
// The collector uses the slave modport; the sources plus downstream consumer use master.
interface mux8_bits_rr_collector_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] D0, D1, D2, D3, D4, D5, D6, D7;
  logic [7:0]       req;
  logic [7:0]       ack;
  logic [WIDTH-1:0] Y;
  logic [2:0]       sel;
  logic             Y_valid;
  logic             Y_ready;

  modport master (
    output D0, D1, D2, D3, D4, D5, D6, D7, req, Y_ready,
    input  ack, Y, sel, Y_valid
  );

  modport slave (
    input  D0, D1, D2, D3, D4, D5, D6, D7, req, Y_ready,
    output ack, Y, sel, Y_valid
  );
endinterface

// File: rtl/mux8_bits_rr_collector.sv
// Eight-source round-robin collector into a single registered valid/ready slot.
// The slot reports the winning channel on sel so replies can be routed back through the demux.
module mux8_bits_rr_collector #(
  parameter int unsigned WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  mux8_bits_rr_collector_if.slave bus
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       last_q, last_d;

  logic             load;
  logic             found;
  logic [2:0]       gnt;
  logic [2:0]       idx;
  logic [WIDTH-1:0] d_gnt;

  assign load = (state_q == StEmpty) || bus.Y_ready;

  // Rotating priority search starting one past the previous winner.
  always_comb begin
    found = 1'b0;
    gnt   = 3'd0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = last_q + 3'(i) + 3'd1;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_comb begin
    d_gnt = bus.D0;
    case (gnt)
      3'd0: d_gnt = bus.D0;
      3'd1: d_gnt = bus.D1;
      3'd2: d_gnt = bus.D2;
      3'd3: d_gnt = bus.D3;
      3'd4: d_gnt = bus.D4;
      3'd5: d_gnt = bus.D5;
      3'd6: d_gnt = bus.D6;
      3'd7: d_gnt = bus.D7;
      default: d_gnt = bus.D0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      y_q     <= '0;
      sel_q   <= 3'd0;
      last_q  <= 3'd7;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (load) begin
      if (found) begin
        state_d = StFull;
        y_d     = d_gnt;
        sel_d   = gnt;
        last_d  = gnt;
      end else begin
        state_d = StEmpty;
      end
    end
  end

  // Gating with rst_n keeps ack silent while reset is asserted.
  always_comb begin
    bus.ack = 8'd0;
    if (load && found && rst_n) begin
      bus.ack = 8'd1 << gnt;
    end
  end

  assign bus.Y       = y_q;
  assign bus.sel     = sel_q;
  assign bus.Y_valid = (state_q == StFull);

endmodule
